// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ID/EX stage and the ALU.
//   - ALU control codes, MIPS-subset opcode and funct values
//   - default datapath widths (ALU_DATA_W, ALU_REG_AW)
//   - decoded-control record produced by alu_ctl_decode
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_AW = 5;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes, instruction[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Source of the ALU B operand
  typedef enum logic [1:0] {
    BSEL_RT   = 2'd0,
    BSEL_SEXT = 2'd1,
    BSEL_ZEXT = 2'd2
  } bsel_e;

  // Decoded controls; dest_rt selects rt (else rd) as write-back register
  typedef struct packed {
    logic [3:0] aluctl;
    bsel_e      bsel;
    logic       dest_rt;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: purely combinational instruction decode.
//   opcode_i  instruction[31:26]
//   funct_i   instruction[5:0]
//   dec_o     ALU code, B-operand select, destination select and flags
// Unknown encodings raise illegal with aluctl=AND and every flag clear.
// R-type encodings (legal or not) write to rd; all other opcodes use rt.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  // Start from the "illegal/no-op" shape and fill in per opcode
  always_comb begin
    dec_o           = '0;
    dec_o.aluctl    = ALU_AND;
    dec_o.bsel      = BSEL_RT;
    dec_o.dest_rt   = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        dec_o.dest_rt   = 1'b0;
        dec_o.reg_write = 1'b1;
        case (funct_i)
          FN_AND:  dec_o.aluctl = ALU_AND;
          FN_OR:   dec_o.aluctl = ALU_OR;
          FN_ADD:  dec_o.aluctl = ALU_ADD;
          FN_SUB:  dec_o.aluctl = ALU_SUB;
          FN_SLT:  dec_o.aluctl = ALU_SLT;
          FN_NOR:  dec_o.aluctl = ALU_NOR;
          default: begin
            dec_o.reg_write = 1'b0;
            dec_o.illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        dec_o.aluctl    = ALU_ADD;
        dec_o.bsel      = BSEL_SEXT;
        dec_o.reg_write = 1'b1;
      end
      OP_ANDI: begin
        dec_o.aluctl    = ALU_AND;
        dec_o.bsel      = BSEL_ZEXT;
        dec_o.reg_write = 1'b1;
      end
      OP_ORI: begin
        dec_o.aluctl    = ALU_OR;
        dec_o.bsel      = BSEL_ZEXT;
        dec_o.reg_write = 1'b1;
      end
      OP_LW: begin
        dec_o.aluctl    = ALU_ADD;
        dec_o.bsel      = BSEL_SEXT;
        dec_o.mem_read  = 1'b1;
        dec_o.reg_write = 1'b1;
      end
      OP_SW: begin
        dec_o.aluctl    = ALU_ADD;
        dec_o.bsel      = BSEL_SEXT;
        dec_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_o.aluctl = ALU_SUB;
        dec_o.branch = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with a 2-entry skid buffer.
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of every held entry
//   in_valid/in_ready upstream handshake; in_* carry the decoded instruction
//   out_valid/out_ready downstream handshake towards the ALU
//   ex_*              registered ALU operands, ALU code and pipeline controls
// The decoded entry is captured in MAIN (presented on ex_*) or SKID (overflow
// while MAIN is stalled). in_ready depends only on the state register.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        ex_aluctl,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int PW = 4 + 3 * DATA_W + REG_AW + 5;

  dec_t              dec;
  logic [DATA_W-1:0] opB;
  logic [REG_AW-1:0] dest;
  logic              regWrite;
  logic [PW-1:0]     newPayload;
  logic [PW-1:0]     mainPayload_q;
  logic [PW-1:0]     skidPayload_q;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              accept;
  logic              drain;
  logic              loadMainNew;
  logic              loadMainSkid;
  logic              loadSkid;

  alu_ctl_decode u_decode (
    .opcode_i (in_opcode),
    .funct_i  (in_funct),
    .dec_o    (dec)
  );

  // Operand B and destination selection; writes to register 0 are dropped
  always_comb begin
    case (dec.bsel)
      BSEL_SEXT: opB = {{(DATA_W-16){in_imm[15]}}, in_imm};
      BSEL_ZEXT: opB = {{(DATA_W-16){1'b0}}, in_imm};
      default:   opB = in_rt_data;
    endcase
    dest     = dec.dest_rt ? in_rt_addr : in_rd_addr;
    regWrite = dec.reg_write & (dest != '0);
  end

  assign newPayload = {dec.aluctl, in_rs_data, opB, in_rt_data, dest, regWrite,
                       dec.mem_read, dec.mem_write, dec.branch, dec.illegal};

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  // flush blocks the accept so an entry offered alongside it is discarded
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready;

  // Buffer occupancy transitions and which slot gets loaded
  always_comb begin
    state_d      = state_q;
    loadMainNew  = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            loadMainNew = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !drain) begin
            state_d  = ST_TWO;
            loadSkid = 1'b1;
          end else if (accept && drain) begin
            loadMainNew = 1'b1;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d      = ST_ONE;
            loadMainSkid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      mainPayload_q <= '0;
      skidPayload_q <= '0;
    end else begin
      state_q <= state_d;
      if (loadMainNew) begin
        mainPayload_q <= newPayload;
      end else if (loadMainSkid) begin
        mainPayload_q <= skidPayload_q;
      end
      if (loadSkid) begin
        skidPayload_q <= newPayload;
      end
    end
  end

  assign {ex_aluctl, ex_a, ex_b, ex_store_data, ex_dest, ex_reg_write,
          ex_mem_read, ex_mem_write, ex_branch, ex_illegal} = mainPayload_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
//   Directed decode table, back-pressure / flush / asynchronous-reset
//   sequences, then randomized traffic against a queue-based reference.
module tb_id_ex_stage;

  typedef struct packed {
    logic [3:0]  aluctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [4:0]  rtA;
    logic [4:0]  rdA;
    exp_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [15:0] in_imm;
  logic [4:0]  in_rt_addr;
  logic [4:0]  in_rd_addr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ex_aluctl;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_illegal;

  int vecCount  = 0;
  int missCount = 0;

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_funct      (in_funct),
    .in_rs_data    (in_rs_data),
    .in_rt_data    (in_rt_data),
    .in_imm        (in_imm),
    .in_rt_addr    (in_rt_addr),
    .in_rd_addr    (in_rd_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ex_aluctl     (ex_aluctl),
    .ex_a          (ex_a),
    .ex_b          (ex_b),
    .ex_store_data (ex_store_data),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_branch     (ex_branch),
    .ex_illegal    (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written straight from the instruction-set rules
  function automatic exp_t refDecode(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [31:0] rs, input logic [31:0] rt,
                                     input logic [15:0] imm, input logic [4:0] rtA,
                                     input logic [4:0] rdA);
    exp_t e;
    e      = '0;
    e.a    = rs;
    e.b    = rt;
    e.sd   = rt;
    e.dest = (op == 6'h00) ? rdA : rtA;
    case (op)
      6'h00: begin
        e.rw = 1'b1;
        if      (fn == 6'h24) e.aluctl = 4'b0000;
        else if (fn == 6'h25) e.aluctl = 4'b0001;
        else if (fn == 6'h20) e.aluctl = 4'b0010;
        else if (fn == 6'h22) e.aluctl = 4'b0110;
        else if (fn == 6'h2A) e.aluctl = 4'b0111;
        else if (fn == 6'h27) e.aluctl = 4'b1100;
        else begin e.rw = 1'b0; e.ill = 1'b1; end
      end
      6'h08: begin e.aluctl = 4'b0010; e.b = 32'($signed(imm)); e.rw = 1'b1; end
      6'h0C: begin e.aluctl = 4'b0000; e.b = 32'(imm); e.rw = 1'b1; end
      6'h0D: begin e.aluctl = 4'b0001; e.b = 32'(imm); e.rw = 1'b1; end
      6'h23: begin e.aluctl = 4'b0010; e.b = 32'($signed(imm)); e.rw = 1'b1; e.mr = 1'b1; end
      6'h2B: begin e.aluctl = 4'b0010; e.b = 32'($signed(imm)); e.mw = 1'b1; end
      6'h04: begin e.aluctl = 4'b0110; e.br = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.dest == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  function automatic exp_t mkExp(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] sd,
                                 input logic [4:0] d, input logic rw, input logic mr,
                                 input logic mw, input logic br, input logic ill);
    exp_t e;
    e = '{aluctl: c, a: a, b: b, sd: sd, dest: d, rw: rw, mr: mr, mw: mw, br: br, ill: ill};
    return e;
  endfunction

  function automatic exp_t getActual();
    exp_t e;
    e = '{aluctl: ex_aluctl, a: ex_a, b: ex_b, sd: ex_store_data, dest: ex_dest,
          rw: ex_reg_write, mr: ex_mem_read, mw: ex_mem_write, br: ex_branch, ill: ex_illegal};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic driveEntry(input logic [5:0] op, input logic [5:0] fn,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input logic [15:0] imm, input logic [4:0] rtA,
                            input logic [4:0] rdA);
    in_opcode  = op;
    in_funct   = fn;
    in_rs_data = rs;
    in_rt_data = rt;
    in_imm     = imm;
    in_rt_addr = rtA;
    in_rd_addr = rdA;
  endtask

  // Offer one entry for one cycle with the downstream ready
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveEntry(v.op, v.fn, v.rs, v.rt, v.imm, v.rtA, v.rdA);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  vec_t tbl[12];
  exp_t q[$];

  initial begin
    exp_t eA, eB, eC, eD;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    driveEntry(6'h00, 6'h20, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0);

    tbl[0]  = '{"r_nor",   6'h00, 6'h27, 32'h0F0F0F0F, 32'hF0F0F0F0, 16'h0000, 5'd2, 5'd3,
                mkExp(4'b1100, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hF0F0F0F0, 5'd3, 1, 0, 0, 0, 0)};
    tbl[1]  = '{"addi",    6'h08, 6'h00, 32'h00000010, 32'h00000055, 16'hFFFC, 5'd4, 5'd9,
                mkExp(4'b0010, 32'h00000010, 32'hFFFFFFFC, 32'h00000055, 5'd4, 1, 0, 0, 0, 0)};
    tbl[2]  = '{"andi",    6'h0C, 6'h00, 32'h00000010, 32'h00000055, 16'hFFFC, 5'd4, 5'd9,
                mkExp(4'b0000, 32'h00000010, 32'h0000FFFC, 32'h00000055, 5'd4, 1, 0, 0, 0, 0)};
    tbl[3]  = '{"ori",     6'h0D, 6'h00, 32'hA5A5A5A5, 32'h00000001, 16'h8000, 5'd5, 5'd1,
                mkExp(4'b0001, 32'hA5A5A5A5, 32'h00008000, 32'h00000001, 5'd5, 1, 0, 0, 0, 0)};
    tbl[4]  = '{"lw",      6'h23, 6'h11, 32'h00001000, 32'h00000002, 16'h0004, 5'd7, 5'd0,
                mkExp(4'b0010, 32'h00001000, 32'h00000004, 32'h00000002, 5'd7, 1, 1, 0, 0, 0)};
    tbl[5]  = '{"sw",      6'h2B, 6'h00, 32'h00002000, 32'hDEADBEEF, 16'h8000, 5'd7, 5'd2,
                mkExp(4'b0010, 32'h00002000, 32'hFFFF8000, 32'hDEADBEEF, 5'd7, 0, 0, 1, 0, 0)};
    tbl[6]  = '{"beq",     6'h04, 6'h00, 32'h00000005, 32'h00000005, 16'h0010, 5'd1, 5'd2,
                mkExp(4'b0110, 32'h00000005, 32'h00000005, 32'h00000005, 5'd1, 0, 0, 0, 1, 0)};
    tbl[7]  = '{"ill_op",  6'h3F, 6'h20, 32'h11111111, 32'h00001234, 16'hFFFF, 5'd8, 5'd9,
                mkExp(4'b0000, 32'h11111111, 32'h00001234, 32'h00001234, 5'd8, 0, 0, 0, 0, 1)};
    tbl[8]  = '{"r_rd0",   6'h00, 6'h20, 32'h00000003, 32'h00000004, 16'h0000, 5'd6, 5'd0,
                mkExp(4'b0010, 32'h00000003, 32'h00000004, 32'h00000004, 5'd0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{"r_slt",   6'h00, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 16'h0000, 5'd6, 5'd31,
                mkExp(4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'd31, 1, 0, 0, 0, 0)};
    tbl[10] = '{"ill_fn",  6'h00, 6'h3F, 32'h00000009, 32'h0000000A, 16'h0000, 5'd2, 5'd6,
                mkExp(4'b0000, 32'h00000009, 32'h0000000A, 32'h0000000A, 5'd6, 0, 0, 0, 0, 1)};
    tbl[11] = '{"addi_r0", 6'h08, 6'h00, 32'h00000001, 32'h00000002, 16'h0001, 5'd0, 5'd3,
                mkExp(4'b0010, 32'h00000001, 32'h00000001, 32'h00000002, 5'd0, 0, 0, 0, 0, 0)};

    // Reset values while rst_n is held low
    #12;
    checkOutput("rst out_valid", 128'(out_valid), 128'(1'b0));
    checkOutput("rst in_ready", 128'(in_ready), 128'(1'b1));
    checkOutput("rst payload", 128'(getActual()), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode table, one entry at a time
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i]);
      checkOutput({tbl[i].name, " valid"}, 128'(out_valid), 128'(1'b1));
      checkOutput(tbl[i].name, 128'(getActual()), 128'(tbl[i].exp));
    end
    @(negedge clk);
    checkOutput("table drained", 128'(out_valid), 128'(1'b0));

    // Back-pressure: two accepted, third stalled, then drain without bubbles
    eA = refDecode(6'h08, 6'h00, 32'h100, 32'h0, 16'h0001, 5'd10, 5'd0);
    eB = refDecode(6'h0D, 6'h00, 32'h200, 32'h0, 16'h0002, 5'd11, 5'd0);
    eC = refDecode(6'h2B, 6'h00, 32'h300, 32'hCAFE, 16'h0003, 5'd12, 5'd0);
    out_ready = 1'b0;
    driveEntry(6'h08, 6'h00, 32'h100, 32'h0, 16'h0001, 5'd10, 5'd0);
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("bp ready after one", 128'(in_ready), 128'(1'b1));
    driveEntry(6'h0D, 6'h00, 32'h200, 32'h0, 16'h0002, 5'd11, 5'd0);
    @(negedge clk);
    checkOutput("bp ready when full", 128'(in_ready), 128'(1'b0));
    driveEntry(6'h2B, 6'h00, 32'h300, 32'hCAFE, 16'h0003, 5'd12, 5'd0);
    @(negedge clk);
    checkOutput("bp still full", 128'(in_ready), 128'(1'b0));
    checkOutput("bp head held", 128'(getActual()), 128'(eA));
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp valid 2", 128'(out_valid), 128'(1'b1));
    checkOutput("bp second", 128'(getActual()), 128'(eB));
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp valid 3", 128'(out_valid), 128'(1'b1));
    checkOutput("bp third", 128'(getActual()), 128'(eC));
    @(negedge clk);
    checkOutput("bp empty", 128'(out_valid), 128'(1'b0));

    // Flush while full with a new entry offered: nothing survives
    out_ready = 1'b0;
    in_valid  = 1'b1;
    driveEntry(6'h00, 6'h25, 32'h1, 32'h2, 16'h0, 5'd1, 5'd2);
    @(negedge clk);
    @(negedge clk);
    eD = refDecode(6'h00, 6'h24, 32'h3, 32'h4, 16'h0, 5'd1, 5'd3);
    driveEntry(6'h00, 6'h24, 32'h3, 32'h4, 16'h0, 5'd1, 5'd3);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush out_valid", 128'(out_valid), 128'(1'b0));
    checkOutput("flush in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("flush stays empty", 128'(out_valid), 128'(1'b0));
    end

    // Asynchronous reset between edges with the buffer full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    driveEntry(6'h23, 6'h00, 32'h40, 32'h5, 16'h0008, 5'd9, 5'd0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre-reset full", 128'(in_ready), 128'(1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", 128'(out_valid), 128'(1'b0));
    checkOutput("async rst in_ready", 128'(in_ready), 128'(1'b1));
    checkOutput("async rst aluctl", 128'(ex_aluctl), 128'(4'b0000));
    checkOutput("async rst payload", 128'(getActual()), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against an ordered-queue reference
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_t e;
      logic [5:0] opList [9];
      logic [5:0] fnList [8];
      bit drn, acc;
      opList = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F};
      fnList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21, 6'h00};
      @(negedge clk);
      checkOutput("rnd out_valid", 128'(out_valid), 128'(q.size() > 0));
      checkOutput("rnd in_ready", 128'(in_ready), 128'(q.size() < 2));
      if (q.size() > 0) checkOutput("rnd payload", 128'(getActual()), 128'(q[0]));
      driveEntry(opList[$urandom_range(0, 8)], fnList[$urandom_range(0, 7)], $urandom, $urandom,
                 16'($urandom), 5'($urandom), 5'($urandom));
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      e   = refDecode(in_opcode, in_funct, in_rs_data, in_rt_data, in_imm, in_rt_addr, in_rd_addr);
      drn = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2) && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
